cpu_fpu_muladd_arbiter: RTL and testbench
=========================================

Name: cpu_fpu_muladd_arbiter

Overview:
Shares one multi-cycle fused multiply-add unit between NUM_REQ requesters (e.g. FPU issue port, vector helper) using round-robin priority.
- Each requester sees the same level handshake the unit itself exposes. Raise request with operands held stable, wait for ready, drop request; ready then falls.
- The arbiter sits between the requesters and the muladd unit. It sequences exactly one operation at a time and captures the result.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
IDX_W, $clog2(NUM_REQ), width of grant index / round-robin pointer

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_request  in  NUM_REQ  per-requester level request
i_op1  in  NUM_REQ*32  packed operand a (requester k at [32k+31:32k])
i_op2  in  NUM_REQ*32  packed operand b
i_op3  in  NUM_REQ*32  packed addend c
o_ready  out  NUM_REQ  per-requester result-valid (one-hot or zero)
o_result  out  32  result for the granted requester
o_busy  out  1  high whenever state != IDLE
o_fpu_request  out  1  request to muladd unit
o_fpu_op1  out  32  operand a muxed from granted port
o_fpu_op2  out  32  operand b
o_fpu_op3  out  32  operand c
i_fpu_ready  in  1  muladd unit ready
i_fpu_result  in  32  muladd unit result

Behaviour:
- Reset values, in effect the clock after i_reset is sampled high:
  - o_ready=0, o_result=0, o_fpu_request=0, state=IDLE, grant=0, rr_ptr=0.
  - Reset wins over every transition.
  - i_reset must also drive the muladd unit's reset, so reset mid-operation leaves both blocks idle. No result is delivered.
- o_fpu_op1/2/3 are a combinational mux of the i_op* slices selected by the grant register. Requesters hold operands stable until their o_ready is seen.
- IDLE state:
  - If i_request != 0: pick the first asserted bit searching upward from rr_ptr, with wrap-around.
  - Register grant and set o_fpu_request<=1; go to BUSY.
  - If i_request == 0: stay in IDLE.
- BUSY state:
  - Hold o_fpu_request=1.
  - When i_fpu_ready is sampled 1: o_result<=i_fpu_result, o_ready[grant]<=i_request[grant], o_fpu_request<=0; go to DONE.
  - A requester that dropped its request early gets no ready, and the result is discarded.
- DONE state:
  - o_ready[grant] clears on the edge after i_request[grant] is sampled 0.
  - Go to IDLE when both i_request[grant]==0 and i_fpu_ready==0 are sampled. On that edge rr_ptr<=grant+1, with wrap at NUM_REQ.
  - This guarantees the unit has returned to its idle state before the next issue. DONE lasts at least 1 cycle.
- Latency: request sampled in IDLE -> o_fpu_request on the next edge. i_fpu_ready sampled -> o_ready[grant] on the next edge. The arbiter adds 2 cycles per operation plus a minimum 1-cycle DONE turnaround.
- Requests arriving during BUSY/DONE are held pending. Arbitration happens only in IDLE.
- Fairness: rr_ptr advances past the last-served port, so no requester waits more than NUM_REQ-1 operations.
- o_result keeps its last value after DONE. Only o_ready qualifies it.
- Protocol error (i_request toggling while still in DONE) is ignored. The exit condition is only re-evaluated in DONE.

Decomposition:
- Shared CPU package:
  - arb_state_t enum {IDLE, BUSY, DONE}, 2-bit.
  - Localparams for the 32-bit operand width.
- One combinational sub-module, cpu_rr_pick:
  - Inputs: request vector, rr_ptr.
  - Outputs: valid, grant index.
  - Reusable by other shared-unit arbiters (divider, sqrt).

Test Plan:
1. Single request: req0 with 0x40000000, 0x40400000, 0x3F800000 (2*3+1) -> o_fpu_request issues once; o_ready[0]=1 with o_result=0x40E00000; req1 never readied.
2. Simultaneous: req0 and req1 raised in the same cycle after reset -> port 0 served first. Port 1 (0x3FC00000, 0x40000000, 0x3F000000) is served next with 0x40600000. o_ready is never 2'b11.
3. Fairness: port 0 re-requests immediately every time while port 1 is held high -> grants alternate 0,1,0,1 over 4 operations.
4. Slow release: requester 0 holds request 10 cycles after o_ready -> o_ready[0] stays high 10 cycles. No new o_fpu_request until request is low and i_fpu_ready is low.
5. Reset mid-BUSY: assert i_reset 3 cycles after grant -> next cycle o_ready=0, o_fpu_request=0, o_busy=0. A following request completes with the correct result.
6. Early withdraw: req1 drops during BUSY -> no o_ready[1] pulse; arbiter returns to IDLE and serves the next pending request.

Source files
------------

// File: rtl/cpu_fpu_muladd_arbiter_pkg.sv
// cpu_fpu_muladd_arbiter_pkg: shared types for the shared-unit arbiters
package cpu_fpu_muladd_arbiter_pkg;
    localparam int OP_W = 32;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
endpackage

// File: rtl/cpu_fpu_muladd_arbiter_rr_pick.sv
// cpu_rr_pick: round-robin picker, first asserted request at or above rr_ptr with wrap
module cpu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   grant
);
    logic [IDX_W-1:0] k;
    assign valid = |request;
    // Scan from the farthest offset down so the nearest hit to rr_ptr wins
    always_comb begin
        grant = '0;
        k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            grant = request[k] ? k : grant;
        end
    end
endmodule

// File: rtl/cpu_fpu_muladd_arbiter.sv
// cpu_fpu_muladd_arbiter: round-robin sharing of one multi-cycle muladd unit
module cpu_fpu_muladd_arbiter
    import cpu_fpu_muladd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NUM_REQ-1:0]      i_request,
    input  logic [NUM_REQ*OP_W-1:0] i_op1,
    input  logic [NUM_REQ*OP_W-1:0] i_op2,
    input  logic [NUM_REQ*OP_W-1:0] i_op3,
    output logic [NUM_REQ-1:0]      o_ready,
    output logic [OP_W-1:0]         o_result,
    output logic                    o_busy,
    output logic                    o_fpu_request,
    output logic [OP_W-1:0]         o_fpu_op1,
    output logic [OP_W-1:0]         o_fpu_op2,
    output logic [OP_W-1:0]         o_fpu_op3,
    input  logic                    i_fpu_ready,
    input  logic [OP_W-1:0]         i_fpu_result
);
    arb_state_t       state;
    logic [IDX_W-1:0] grant, rr_ptr, pick;
    logic             pick_valid;

    cpu_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .request(i_request),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .grant  (pick)
    );

    assign o_busy    = state != IDLE;
    assign o_fpu_op1 = i_op1[OP_W*grant +: OP_W];
    assign o_fpu_op2 = i_op2[OP_W*grant +: OP_W];
    assign o_fpu_op3 = i_op3[OP_W*grant +: OP_W];

    // DONE waits for the unit to drop ready too, so it is idle before the next issue
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            o_ready       <= '0;
            o_result      <= '0;
            o_fpu_request <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    grant         <= pick;
                    o_fpu_request <= 1'b1;
                    state         <= BUSY;
                end
                BUSY: if (i_fpu_ready) begin
                    o_result      <= i_fpu_result;
                    o_ready       <= i_request & (NUM_REQ'(1) << grant);
                    o_fpu_request <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    o_ready <= o_ready & i_request;
                    if (!i_request[grant] && !i_fpu_ready) begin
                        rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_fpu_muladd_arbiter.sv
// tb_cpu_fpu_muladd_arbiter: directed bench with a lookup-table muladd unit model
module tb_cpu_fpu_muladd_arbiter;
    localparam int LAT = 6;
    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [1:0]  i_request = '0;
    logic [63:0] i_op1 = '0, i_op2 = '0, i_op3 = '0;
    logic [1:0]  o_ready;
    logic [31:0] o_result, o_fpu_op1, o_fpu_op2, o_fpu_op3;
    logic        o_busy, o_fpu_request;
    logic        i_fpu_ready;
    logic [31:0] i_fpu_result;

    cpu_fpu_muladd_arbiter #(.NUM_REQ(2)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request),
        .i_op1(i_op1), .i_op2(i_op2), .i_op3(i_op3),
        .o_ready(o_ready), .o_result(o_result), .o_busy(o_busy),
        .o_fpu_request(o_fpu_request), .o_fpu_op1(o_fpu_op1),
        .o_fpu_op2(o_fpu_op2), .o_fpu_op3(o_fpu_op3),
        .i_fpu_ready(i_fpu_ready), .i_fpu_result(i_fpu_result)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fma_lut(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        case ({a, b, c})
            {32'h40000000, 32'h40400000, 32'h3F800000}: return 32'h40E00000;
            {32'h3FC00000, 32'h40000000, 32'h3F000000}: return 32'h40600000;
            {32'h40000000, 32'h40000000, 32'h00000000}: return 32'h40800000;
            {32'h3F800000, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    int fpu_cnt;
    always @(posedge i_clock) begin
        if (i_reset || !o_fpu_request) begin
            i_fpu_ready <= 1'b0;
            fpu_cnt     <= 0;
        end else if (!i_fpu_ready) begin
            if (fpu_cnt == LAT - 1) begin
                i_fpu_ready  <= 1'b1;
                i_fpu_result <= fma_lut(o_fpu_op1, o_fpu_op2, o_fpu_op3);
            end else fpu_cnt <= fpu_cnt + 1;
        end
    end

    int issues = 0, rdy1_pulses = 0, both_hi = 0;
    int served[$];
    logic req_q = 1'b0;
    logic [1:0] rdy_q = '0;
    always @(posedge i_clock) begin
        if (o_fpu_request && !req_q) issues++;
        if (o_ready[0] && !rdy_q[0]) served.push_back(0);
        if (o_ready[1] && !rdy_q[1]) begin
            served.push_back(1);
            rdy1_pulses++;
        end
        if (o_ready == 2'b11) both_hi++;
        req_q = o_fpu_request;
        rdy_q = o_ready;
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        i_op1[32*p +: 32] = a;
        i_op2[32*p +: 32] = b;
        i_op3[32*p +: 32] = c;
    endtask

    task automatic wait_ready(input int p, input string tag);
        for (int k = 0; k < 60; k++) begin
            if (o_ready[p]) return;
            step(1);
        end
        check({tag, "_timeout"}, 32'(o_ready[p]), 1);
    endtask

    task automatic wait_any(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (|o_ready) return;
            step(1);
        end
        check({tag, "_timeout"}, 32'(|o_ready), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (!o_busy) return;
            step(1);
        end
        check({tag, "_timeout"}, 32'(o_busy), 0);
    endtask

    task automatic wait_fpu_req(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (o_fpu_request) return;
            step(1);
        end
        check({tag, "_timeout"}, 32'(o_fpu_request), 1);
    endtask

    initial begin
        int n0, r1, s, p, hi, fr;
        step(2);
        check("rst_ready", 32'(o_ready), 0);
        check("rst_result", o_result, 0);
        check("rst_fpu_req", 32'(o_fpu_request), 0);
        check("rst_busy", 32'(o_busy), 0);
        i_reset = 1'b0;
        step(1);
        // single request
        set_ops(0, 32'h40000000, 32'h40400000, 32'h3F800000);
        set_ops(1, 32'h3FC00000, 32'h40000000, 32'h3F000000);
        n0 = issues;
        r1 = rdy1_pulses;
        i_request = 2'b01;
        wait_fpu_req("t1_issue");
        check("t1_op1", o_fpu_op1, 32'h40000000);
        wait_ready(0, "t1_ready");
        check("t1_result", o_result, 32'h40E00000);
        i_request = 2'b00;
        wait_idle("t1_idle");
        step(3);
        check("t1_issues", 32'(issues - n0), 1);
        check("t1_no_ready1", 32'(rdy1_pulses - r1), 0);
        check("t1_result_kept", o_result, 32'h40E00000);
        // simultaneous requests after reset
        i_reset = 1'b1;
        step(2);
        i_reset = 1'b0;
        s = served.size();
        i_request = 2'b11;
        wait_ready(0, "t2_ready0");
        check("t2_result0", o_result, 32'h40E00000);
        i_request[0] = 1'b0;
        wait_ready(1, "t2_ready1");
        check("t2_result1", o_result, 32'h40600000);
        i_request[1] = 1'b0;
        wait_idle("t2_idle");
        step(3);
        check("t2_served", 32'(served.size() - s), 2);
        if (served.size() >= s + 2) begin
            check("t2_first", 32'(served[s]), 0);
            check("t2_second", 32'(served[s+1]), 1);
        end
        check("t2_never_both", 32'(both_hi), 0);
        // fairness under constant contention
        i_request = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_any("t3_ready");
            p = o_ready[1] ? 1 : 0;
            check("t3_grant", 32'(p), 32'(i % 2));
            i_request[p] = 1'b0;
            wait_idle("t3_idle");
            i_request[p] = 1'b1;
        end
        i_request = 2'b00;
        wait_idle("t3_end");
        step(2);
        // slow release holds ready and blocks the next issue
        i_request = 2'b01;
        wait_ready(0, "t4_ready");
        i_request[1] = 1'b1;
        n0 = issues;
        hi = 0;
        fr = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            hi += int'(o_ready[0]);
            fr += int'(o_fpu_request);
        end
        check("t4_hold", 32'(hi), 10);
        check("t4_no_issue", 32'(fr), 0);
        check("t4_busy", 32'(o_busy), 1);
        check("t4_issue_cnt", 32'(issues - n0), 0);
        i_request[0] = 1'b0;
        wait_ready(1, "t4_ready1");
        check("t4_result1", o_result, 32'h40600000);
        i_request = 2'b00;
        wait_idle("t4_idle");
        step(2);
        // reset in the middle of an operation
        s = served.size();
        i_request = 2'b01;
        wait_fpu_req("t5_issue");
        step(2);
        i_reset = 1'b1;
        i_request = 2'b00;
        step(1);
        check("t5_ready", 32'(o_ready), 0);
        check("t5_fpu_req", 32'(o_fpu_request), 0);
        check("t5_busy", 32'(o_busy), 0);
        check("t5_result", o_result, 0);
        i_reset = 1'b0;
        step(1);
        check("t5_no_serve", 32'(served.size() - s), 0);
        set_ops(0, 32'h40000000, 32'h40000000, 32'h00000000);
        i_request = 2'b01;
        wait_ready(0, "t5_ready_after");
        check("t5_result_after", o_result, 32'h40800000);
        i_request = 2'b00;
        wait_idle("t5_idle");
        step(2);
        // early withdraw by port 1 while port 0 waits
        set_ops(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        r1 = rdy1_pulses;
        i_request = 2'b10;
        wait_fpu_req("t6_issue");
        check("t6_op1", o_fpu_op1, 32'h3FC00000);
        i_request = 2'b11;
        step(2);
        i_request[1] = 1'b0;
        wait_ready(0, "t6_ready0");
        check("t6_result0", o_result, 32'h40000000);
        i_request = 2'b00;
        wait_idle("t6_idle");
        step(3);
        check("t6_no_ready1", 32'(rdy1_pulses - r1), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
